eta_seq_mult: RTL and testbench
===============================

ETA_SEQ_MULT -- requirements
Module: eta_seq_mult

Interface
REQ-001 The block SHALL have parameter APPROX, default 1, which selects the partial-sum adder: 1 = ECEPTA approximate adder (REQ-012), 0 = exact 16-bit adder with carry-out.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port clear  input  1  synchronous abort; returns the block to IDLE.
REQ-005 The block SHALL have port in_valid  input  1  operand pair offered.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port mcand  input  16  multiplicand, unsigned.
REQ-008 The block SHALL have port mplier  input  16  multiplier, unsigned.
REQ-009 The block SHALL have port out_valid  output  1  product available.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes product.
REQ-011 The block SHALL have ports product  output  32  unsigned (approximate) product; and busy  output  1  high in BUSY.

Function
REQ-012 With APPROX=1, the block SHALL compute each partial sum s = f(x,y) exactly as the team's ECEPTA_adder: s[0]=x0|y0; s[i]=(xi|yi)|(x(i-1)&y(i-1)) for i=1..14; s[15]=(x15^y15)|(x14&y14); cout=(x15&y15)|((x15^y15)&x14&y14).
REQ-013 With APPROX=0, the block SHALL compute {cout,s} = x+y exactly.
REQ-014 The block SHALL implement states IDLE, BUSY, DONE; one adder instance, reused every BUSY cycle.
REQ-015 in_ready SHALL equal (state==IDLE); operands SHALL be accepted on an edge with in_valid&in_ready.
REQ-016 On accept, the block SHALL latch mcand into M, load HI=0, LO=mplier, cnt=0, and enter BUSY; if mcand==0 or mplier==0 it SHALL instead enter DONE with HI=LO=0.
REQ-017 For each BUSY edge, the block SHALL compute {c,t} = LO[0] ? f(HI,M) : {0,HI}, then set {HI,LO} = {c,t,LO}>>1 (33-bit logical shift right), and increment cnt.
REQ-018 The block SHALL perform exactly 16 BUSY steps (cnt 0..15); the edge performing step cnt==15 SHALL move to DONE.
REQ-019 Latency: for a nonzero-operand accept at edge E0, out_valid SHALL be first high after edge E16; zero-operand shortcut: high after E0.
REQ-020 product SHALL equal {HI,LO}; it SHALL be held stable while out_valid is high.
REQ-021 out_valid SHALL equal (state==DONE); DONE->IDLE SHALL occur on an edge with out_ready high; out_valid SHALL be held indefinitely while out_ready is low.
REQ-022 in_ready SHALL be low in DONE even if out_ready is high (no same-cycle accept); the next accept SHALL occur no earlier than the edge after DONE->IDLE.
REQ-023 mcand/mplier/in_valid changes in BUSY or DONE SHALL have no effect.
REQ-024 clear high at an edge SHALL force state IDLE, HI=LO=0, cnt=0, overriding accept, stepping and output handshake; any product in flight SHALL be discarded.
REQ-025 busy SHALL equal (state==BUSY).

Reset
REQ-026 While rst is high, the block SHALL asynchronously force state IDLE, HI=LO=0, M=0, cnt=0.
REQ-027 Reset outputs SHALL be: in_ready=1, out_valid=0, busy=0, product=0.
REQ-028 rst asserted mid-BUSY or in DONE SHALL discard the operation; the first accept after rst deassertion SHALL behave as from power-up.

Verification
REQ-029 APPROX=1, mcand=0x0003, mplier=0x0003 -> out_valid after 16 cycles, product=0x00000007 (APPROX=0: 0x00000009).
REQ-030 APPROX=0, mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001, out_valid first high after edge E16.
REQ-031 mcand=0x1234, mplier=0x0000 -> out_valid one cycle after accept, product=0, busy never high.
REQ-032 Back-to-back: out_ready held low 5 cycles after out_valid -> product stable, in_ready low throughout; out_ready=1 -> IDLE next edge, second operand pair accepted one edge later.
REQ-033 clear pulsed at BUSY cnt==7 -> next cycle in_ready=1, busy=0, out_valid=0, product=0; new pair 0x0003 x 0x0001 -> product=0x00000003.
REQ-034 rst pulsed asynchronously mid-BUSY (between edges) -> outputs at reset values immediately, no out_valid for aborted operation.

Source files
------------

// File: rtl/eta_seq_mult.sv
// eta_seq_mult: 16x16 shift-add sequential multiplier with selectable ECEPTA approximate or exact partial-sum adder
module eta_seq_mult #(
  parameter int APPROX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [3:0] cnt_q, cnt_d;
  logic [16:0] sum, step;
  logic zero_op;
  if (APPROX != 0) begin : g_eta
    assign sum = {(hi_q[15] & m_q[15]) | ((hi_q[15] ^ m_q[15]) & hi_q[14] & m_q[14]),
                  (hi_q[15] ^ m_q[15]) | (hi_q[14] & m_q[14]),
                  hi_q[14:1] | m_q[14:1] | (hi_q[13:0] & m_q[13:0]),
                  hi_q[0] | m_q[0]};
  end else begin : g_exact
    assign sum = {1'b0, hi_q} + {1'b0, m_q};
  end
  assign step = lo_q[0] ? sum : {1'b0, hi_q};
  assign zero_op = (mcand == 16'd0) || (mplier == 16'd0);
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    cnt_d = cnt_q;
    if (clear) begin
      state_d = IDLE;
      hi_d = '0;
      lo_d = '0;
      cnt_d = '0;
    end else if (state_q == IDLE && in_valid) begin
      state_d = zero_op ? DONE : BUSY;
      m_d = mcand;
      hi_d = '0;
      lo_d = zero_op ? 16'd0 : mplier;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      {hi_d, lo_d} = {step, lo_q[15:1]};
      cnt_d = cnt_q + 4'd1;
      state_d = (cnt_q == 4'hF) ? DONE : BUSY;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign busy = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product = {hi_q, lo_q};
endmodule

// File: tb/tb_eta_seq_mult.sv
// tb_eta_seq_mult: scoreboard bench running approximate and exact multiplier instances side by side
module tb_eta_seq_mult;
  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready;
  logic [15:0] mcand, mplier;
  logic in_ready1, out_valid1, busy1, in_ready0, out_valid0, busy0;
  logic [31:0] product1, product0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  eta_seq_mult #(.APPROX(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .mcand(mcand), .mplier(mplier), .out_valid(out_valid1), .out_ready(out_ready),
    .product(product1), .busy(busy1)
  );
  eta_seq_mult #(.APPROX(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .mcand(mcand), .mplier(mplier), .out_valid(out_valid0), .out_ready(out_ready),
    .product(product0), .busy(busy0)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] eta(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] r;
    r[0] = x[0] | y[0];
    for (int i = 1; i < 15; i++) r[i] = x[i] | y[i] | (x[i-1] & y[i-1]);
    r[15] = (x[15] ^ y[15]) | (x[14] & y[14]);
    r[16] = (x[15] & y[15]) | ((x[15] ^ y[15]) & x[14] & y[14]);
    return r;
  endfunction
  function automatic logic [31:0] model_approx(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] hi, lo;
    logic [16:0] t;
    if (a == 16'd0 || b == 16'd0) return 32'd0;
    hi = 16'd0;
    lo = b;
    for (int k = 0; k < 16; k++) begin
      t = lo[0] ? eta(hi, a) : {1'b0, hi};
      lo = {t[0], lo[15:1]};
      hi = t[16:1];
    end
    return {hi, lo};
  endfunction
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
    q1.push_back(model_approx(a, b));
    q0.push_back(32'(a) * 32'(b));
  endtask
  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    mcand = a;
    mplier = b;
    push_exp(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mcand = 16'($urandom);
    mplier = 16'($urandom);
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b want 1", in_ready1, in_ready0); end
    n_checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b want 0", out_valid1, out_valid0); end
    n_checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0", busy1, busy0); end
    n_checks++; if (product1 !== 32'd0 || product0 !== 32'd0) begin n_fail++; $display("FAIL reset_product got %h/%h want 0", product1, product0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    int c;
    accept(16'h0003, 16'h0003);
    n_checks++; if (busy1 !== 1'b1 || in_ready1 !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy1, in_ready1); end
    wait_done(c);
    n_checks++; if (c != 16) begin n_fail++; $display("FAIL basic_latency got %0d want 16", c); end
    n_checks++; if (product1 !== q1.pop_front() || product1 !== 32'h7) begin n_fail++; $display("FAIL basic_approx got %h want 00000007", product1); end
    n_checks++; if (product0 !== q0.pop_front() || product0 !== 32'h9) begin n_fail++; $display("FAIL basic_exact got %h want 00000009", product0); end
    release_out();
  endtask
  task automatic test_max();
    int c;
    logic [31:0] e1, e0;
    accept(16'hFFFF, 16'hFFFF);
    wait_done(c);
    e1 = q1.pop_front();
    e0 = q0.pop_front();
    n_checks++; if (c != 16 || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL max_latency got %0d want 16", c); end
    n_checks++; if (product0 !== e0 || product0 !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_exact got %h want fffe0001", product0); end
    n_checks++; if (product1 !== e1) begin n_fail++; $display("FAIL max_approx got %h want %h", product1, e1); end
    release_out();
  endtask
  task automatic test_zero();
    logic [15:0] za[2] = '{16'h1234, 16'h0000};
    logic [15:0] zb[2] = '{16'h0000, 16'h8001};
    for (int k = 0; k < 2; k++) begin
      accept(za[k], zb[k]);
      n_checks++; if (out_valid1 !== 1'b1 || out_valid0 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_shortcut%0d got valid=%b busy=%b want 1/0", k, out_valid1, busy1); end
      n_checks++; if (product1 !== q1.pop_front() || product0 !== q0.pop_front() || product1 !== 32'd0) begin n_fail++; $display("FAIL zero_product%0d got %h/%h want 0", k, product1, product0); end
      release_out();
    end
  endtask
  task automatic test_back_to_back();
    int c;
    logic [31:0] e1, e0;
    logic ok;
    accept(16'hBEEF, 16'h1357);
    wait_done(c);
    e1 = q1.pop_front();
    e0 = q0.pop_front();
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      if (product1 !== e1 || product0 !== e0 || in_ready1 !== 1'b0 || out_valid1 !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (!ok || product1 !== e1 || product0 !== e0) begin n_fail++; $display("FAIL b2b_hold got %h/%h want %h/%h", product1, product0, e1, e0); end
    out_ready = 1'b1;
    mcand = 16'h00A5;
    mplier = 16'h0F0F;
    push_exp(16'h00A5, 16'h0F0F);
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got in_ready=%b valid=%b busy=%b want 1/0/0", in_ready1, out_valid1, busy1); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (busy1 !== 1'b1 || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b/%b want 1", busy1, busy0); end
    wait_done(c);
    n_checks++; if (c != 16) begin n_fail++; $display("FAIL b2b_latency got %0d want 16", c); end
    n_checks++; if (product1 !== q1.pop_front() || product0 !== q0.pop_front()) begin n_fail++; $display("FAIL b2b_second got %h/%h", product1, product0); end
    release_out();
  endtask
  task automatic test_clear();
    int c;
    accept(16'hABCD, 16'h1234);
    repeat (7) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    void'(q1.pop_back());
    void'(q0.pop_back());
    n_checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0 || product1 !== 32'd0 || product0 !== 32'd0) begin n_fail++; $display("FAIL clear_state got in_ready=%b busy=%b valid=%b product=%h want 1/0/0/0", in_ready1, busy1, out_valid1, product1); end
    accept(16'h0003, 16'h0001);
    wait_done(c);
    n_checks++; if (c != 16 || product1 !== q1.pop_front() || product0 !== q0.pop_front() || product1 !== 32'h3) begin n_fail++; $display("FAIL clear_next got %h/%h lat %0d want 00000003", product1, product0, c); end
    release_out();
  endtask
  task automatic test_async_rst();
    int c;
    logic seen;
    accept(16'h7777, 16'h9999);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(q1.pop_back());
    void'(q0.pop_back());
    n_checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0 || product1 !== 32'd0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL async_rst got in_ready=%b busy=%b valid=%b product=%h want 1/0/0/0", in_ready1, busy1, out_valid1, product1); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid1 || out_valid0 || busy1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL async_rst_ghost got activity want none"); end
    accept(16'h0005, 16'h0007);
    wait_done(c);
    n_checks++; if (c != 16 || product1 !== q1.pop_front() || product0 !== q0.pop_front() || product0 !== 32'd35) begin n_fail++; $display("FAIL async_rst_next got %h/%h lat %0d", product1, product0, c); end
    release_out();
  endtask
  task automatic test_random();
    int c;
    for (int k = 0; k < 8; k++) begin
      accept(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF)));
      wait_done(c);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      n_checks++; if (c != 16 || product1 !== q1.pop_front() || product0 !== q0.pop_front()) begin n_fail++; $display("FAIL random%0d got %h/%h lat %0d", k, product1, product0, c); end
      release_out();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_clear();
    test_async_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
